// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
// Shared definitions for the elastic pipeline stage register:
//   - skid_state_e    : buffer fill state, encoded as {skid_v, main_v}
//   - ZeroWord        : all-zero bubble word (decodes as a NOP)
//   - *_LSB / *_W     : payload field offsets for the per-stage packings
//   - state_occupancy : number of entries held in a given state
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    // Bit 1 is the skid-entry valid, bit 0 the main-entry valid.
    // 2'b10 is unreachable and is recovered to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } skid_state_e;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // IF/ID payload packing: {pc, inst}
    localparam int unsigned IFID_INST_LSB   = 0;
    localparam int unsigned IFID_INST_W     = 32;
    localparam int unsigned IFID_PC_LSB     = 32;
    localparam int unsigned IFID_PC_W       = 32;

    // EX/MEM payload packing: {store_data, mem_addr, wdata, wreg, wd}
    localparam int unsigned EXMEM_WD_LSB    = 0;
    localparam int unsigned EXMEM_WD_W      = 5;
    localparam int unsigned EXMEM_WREG_LSB  = 5;
    localparam int unsigned EXMEM_WDATA_LSB = 6;
    localparam int unsigned EXMEM_ADDR_LSB  = 38;
    localparam int unsigned EXMEM_STORE_LSB = 70;
    localparam int unsigned EXMEM_DATA_W    = 102;

    // Entries held in a given fill state.
    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline stage register with a 2-entry main/skid buffer. Because
// in_ready comes from a flop, no combinational path runs from out_ready back
// upstream. Vacated entries are zeroed, so out_data is a bubble whenever
// out_valid is low. flush empties the buffer; stall_cnt counts back-pressure
// cycles and saturates.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   flush      discard all held entries (and any concurrent input) this cycle
//   in_valid   upstream payload valid
//   in_data    upstream payload [DATA_W]
//   in_ready   buffer can accept (registered)
//   out_valid  main entry valid (registered)
//   out_data   main entry payload [DATA_W] (registered)
//   out_ready  downstream accepts
//   occupancy  entries held: 0, 1 or 2 (registered)
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating [CNT_W]
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [DATA_W-1:0] BUBBLE  = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    skid_state_e       state_r;
    skid_state_e       state_nx_s;
    logic [DATA_W-1:0] main_q_r;
    logic [DATA_W-1:0] main_q_nx_s;
    logic [DATA_W-1:0] skid_q_r;
    logic [DATA_W-1:0] skid_q_nx_s;
    logic              in_ready_r;
    logic              in_ready_nx_s;
    logic              out_valid_r;
    logic              out_valid_nx_s;
    logic [1:0]        occ_r;
    logic [1:0]        occ_nx_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              in_fire_s;
    logic              out_fire_s;

    // Handshakes are qualified only by registered ready/valid.
    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // State and data registers; the status outputs are registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_q_r    <= BUBBLE;
            skid_q_r    <= BUBBLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occ_r       <= 2'd0;
        end else begin
            state_r     <= state_nx_s;
            main_q_r    <= main_q_nx_s;
            skid_q_r    <= skid_q_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            occ_r       <= occ_nx_s;
        end
    end

    // Next-state and next-data selection; flush overrides normal operation.
    always_comb begin
        state_nx_s  = state_r;
        main_q_nx_s = main_q_r;
        skid_q_nx_s = skid_q_r;
        if (flush) begin
            state_nx_s  = ST_EMPTY;
            main_q_nx_s = BUBBLE;
            skid_q_nx_s = BUBBLE;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_nx_s  = ST_ONE;
                        main_q_nx_s = in_data;
                    end else begin
                        state_nx_s  = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_q_nx_s = in_data;
                    end else if (in_fire_s) begin
                        state_nx_s  = ST_TWO;
                        skid_q_nx_s = in_data;
                    end else if (out_fire_s) begin
                        state_nx_s  = ST_EMPTY;
                        main_q_nx_s = BUBBLE;
                    end else begin
                        state_nx_s  = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire_s) begin
                        state_nx_s  = ST_ONE;
                        main_q_nx_s = skid_q_r;
                        skid_q_nx_s = BUBBLE;
                    end else begin
                        state_nx_s  = ST_TWO;
                    end
                end
                default: begin
                    state_nx_s  = ST_EMPTY;
                    main_q_nx_s = BUBBLE;
                    skid_q_nx_s = BUBBLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the next state so they can be flopped.
    always_comb begin
        in_ready_nx_s  = (state_nx_s != ST_TWO);
        out_valid_nx_s = (state_nx_s != ST_EMPTY);
        occ_nx_s       = state_occupancy(state_nx_s);
    end

    // Back-pressure counter: counts stalled-valid cycles (flush cycles
    // included), holds at all-ones, and is cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_q_r;
    assign occupancy = occ_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed and randomized stimulus for pipe_skid_reg. The reference model is
// a FIFO queue of at most two payloads plus a saturating integer counter;
// every cycle all outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    logic [DATA_W-1:0] mq[$];
    int unsigned       m_cnt = 0;
    bit                m_acc = 1'b0;
    int                tests = 0;
    int                fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
        check({tag, ":out_valid"}, {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        check({tag, ":out_data"},  out_data, exp_data);
        check({tag, ":occupancy"}, {30'd0, occupancy}, mq.size());
        check({tag, ":in_ready"},  {31'd0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
        check({tag, ":stall_cnt"}, {28'd0, stall_cnt}, m_cnt);
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, compare.
    task automatic step(input string tag, input bit r, input bit fl, input bit iv,
                        input logic [31:0] d, input bit ordy);
        bit ifire;
        bit ofire;
        rst = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        ifire = iv && (mq.size() < 2);
        ofire = (mq.size() > 0) && ordy;
        @(posedge clk);
        m_acc = 1'b0;
        if (r) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if ((mq.size() > 0) && !ordy && (m_cnt < CNT_SAT)) m_cnt++;
            if (fl) begin
                mq.delete();
            end else begin
                if (ofire) mq.delete(0);
                if (ifire) begin
                    mq.push_back(d);
                    m_acc = 1'b1;
                end
            end
        end
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [31:0] cur;
        bit iv, ordy, fl;
        bit got;

        // Reset
        step("reset", 1, 0, 0, 32'h0, 0);
        step("reset", 1, 0, 0, 32'h0, 0);

        // Single payload latency
        step("first", 0, 0, 1, 32'hA5A5_0001, 1);
        check("first_data_const", out_data, 32'hA5A5_0001);
        step("first_drain", 0, 0, 0, 32'h0, 1);

        // Back-to-back stream
        for (int i = 1; i <= 8; i++) step("stream", 0, 0, 1, i, 1);
        step("stream_drain", 0, 0, 0, 32'h0, 1);
        check("stream_stall_const", {28'd0, stall_cnt}, 32'd0);

        // Back-pressure with skid fill, then release
        step("bp_10", 0, 0, 1, 32'h10, 0);
        step("bp_11", 0, 0, 1, 32'h11, 0);
        for (int i = 0; i < 3; i++) step("bp_hold12", 0, 0, 1, 32'h12, 0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step("bp_release", 0, 0, 1, 32'h12, 1);
            got = m_acc;
        end
        check("bp_accept_12", {31'd0, got}, 32'd1);
        for (int i = 0; i < 3; i++) step("bp_drain", 0, 0, 0, 32'h0, 1);

        // Flush in TWO with a concurrent input
        step("fl_20", 0, 0, 1, 32'h20, 0);
        step("fl_21", 0, 0, 1, 32'h21, 0);
        step("flush", 0, 1, 1, 32'h22, 0);
        check("flush_out_data_const", out_data, 32'h0);
        for (int i = 0; i < 3; i++) step("fl_after", 0, 0, 0, 32'h0, 1);

        // Saturation of the counter
        step("sat_fill", 0, 0, 1, 32'h30, 0);
        for (int i = 0; i < 20; i++) step("sat", 0, 0, 0, 32'h0, 0);
        check("sat_const", {28'd0, stall_cnt}, 32'hF);
        step("sat_drain", 0, 0, 0, 32'h0, 1);

        // Reset in TWO, then resume traffic
        step("rst_40", 0, 0, 1, 32'h40, 0);
        step("rst_41", 0, 0, 1, 32'h41, 0);
        step("rst_mid", 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step("rst_after", 0, 0, 0, 32'h0, 1);
        step("rst_new", 0, 0, 1, 32'h50, 1);
        step("rst_new_drain", 0, 0, 0, 32'h0, 1);

        // Randomized traffic; upstream holds its payload until accepted
        cur = $urandom;
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            step("rand", 0, fl, iv, cur, ordy);
            if (m_acc) cur = $urandom;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
